reg_file_wb: RTL
================

// Module: reg_file_wb
// PURPOSE
//  Architectural register file and writeback port of the single-cycle MIPS core.
//  - Supplies Rdata1/Rdata2 to the ALU stage.
//  - Rdata2 also feeds the data-memory stage as SW store data.
//  - Commits the data-memory stage's Wdata to the destination register at the clock edge.
//  - Decodes, from the current instruction word, whether a write happens and which register it targets.
//  - Holds a committed-write counter and a debug read port for the bench.
// PARAMETERS
//  NREG    32  number of architectural registers (index width 5, fixed)
//  DATA_W  32  register width
//  Opcode/funct constants (LW, SW, JAL, JALR, JR, ADDI...) come from common_param.vh.
// PORTS
//  CLK       in   1   single clock; all state updates on posedge
//  RST       in   1   synchronous, active-high reset
//  Ins       in   32  current instruction word (same word the data-memory stage sees)
//  Wdata     in   32  writeback value from data-memory stage (load data / nextPC / ALU result)
//  Rdata1    out  32  GPR[Ins[25:21]] (rs), combinational
//  Rdata2    out  32  GPR[Ins[20:16]] (rt), combinational
//  DbgAdr    in   5   debug read index
//  DbgData   out  32  GPR[DbgAdr], combinational
//  WrCount   out  32  number of committed non-$0 writes since reset
// BEHAVIOUR
//  Field extraction:
//   Opcode=Ins[31:26], Rs=Ins[25:21], Rt=Ins[20:16], Rd=Ins[15:11], Funct=Ins[5:0].
//  Write decode, combinational (WE, WA):
//   - Opcode 0, Funct!=JR: WE=1, WA=Rd. JALR uses Rd as encoded; 31 is typical.
//   - Opcode 0, Funct==JR: WE=0.
//   - LW, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI: WE=1, WA=Rt.
//   - JAL: WE=1, WA=31.
//   - SW, BEQ, BNE, J, any undefined opcode: WE=0.
//  Commit, posedge CLK:
//   - RST=1: all GPRs <= 0; WrCount <= 0. RST has priority over any write in that cycle.
//   - Otherwise, if WE && WA!=0: GPR[WA] <= Wdata; WrCount <= WrCount+1.
//   - WrCount wraps at 2^32 to 0.
//   - WE && WA==0: no state change; WrCount unchanged.
//  Reads:
//   - Purely combinational from the array; index 0 always returns 0.
//   - Read-during-write to the same index returns the OLD value until the edge. This is the
//     single-cycle contract: an instruction reads its sources before its own writeback lands.
//  Reset values: after the reset edge, Rdata1 = Rdata2 = DbgData = 0 and WrCount = 0.
//  Reset mid-program: a write decoded in the reset cycle is dropped. No partial state survives.
//  Latency: writeback visible to reads 0 cycles after the committing edge, i.e. the next instruction.
//  No X propagation: an undefined opcode is a no-write.
// STRUCTURE
//  - Opcode/funct localparams stay in common_param.vh, shared with the data-memory stage and decode.
//  - Sub-module wb_decode: combinational Ins -> {WE, WA}.
//    Reused later by a hazard/forwarding unit when the core is pipelined.
//  - The array is written with nonblocking assigns in a single always @(posedge CLK).
// TESTING
//  1 Reset: preload via writes; RST=1 for 1 cycle -> DbgData=0 for all 32 indices; WrCount=0.
//  2 ADDI $5 (Ins=0x20050000), Wdata=0xDEADBEEF -> after edge GPR[5]=0xDEADBEEF, WrCount=1.
//    Then Ins with rs=5 -> Rdata1=0xDEADBEEF.
//  3 R-type ADD rd=0, Wdata=0x1234 -> GPR[0] stays 0, Rdata of index 0 = 0, WrCount unchanged.
//  4 JAL (opcode 0x03), Wdata=0x00400008 -> GPR[31]=0x00400008.
//    JR $31 (funct 0x08) with Wdata=0xFFFF -> no write.
//  5 SW rt=7 with Wdata=0x55 -> GPR[7] unchanged; Rdata2 = prior GPR[7].
//    LW rt=7, Wdata=0x55 -> GPR[7]=0x55.
//  6 Read-during-write: ADDI rs=rt=9, GPR[9]=1, Wdata=2 -> Rdata1=1 before the edge, 2 after.
//    Same cycle with RST=1 -> GPR[9]=0.

Source files
------------

// File: rtl/reg_file_wb_pkg.sv
// Shared constants and types for the register file / writeback slice:
// array geometry, MIPS opcode/funct encodings and the decoded writeback control.
package reg_file_wb_pkg;

   localparam int NREG   = 32;
   localparam int DATA_W = 32;
   localparam int AW     = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;

   localparam logic [AW-1:0] RA_IDX = 5'd31;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] wa;
   } wb_ctrl_t;

endpackage

// File: rtl/reg_file_wb_decode.sv
// Combinational writeback decode: instruction fields -> {write enable, write address}.
// Kept standalone so a later hazard/forwarding unit can reuse it unchanged.
module reg_file_wb_decode
   import reg_file_wb_pkg::*;
(
   input  logic [5:0]    opcode_i,
   input  logic [AW-1:0] rt_i,
   input  logic [AW-1:0] rd_i,
   input  logic [5:0]    funct_i,
   output wb_ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (opcode_i)
         OP_RTYPE: begin
            // JALR is just another R-type here: it links into whatever rd encodes
            if (funct_i != FN_JR) begin
               ctrl_o.we = 1'b1;
               ctrl_o.wa = rd_i;
            end
         end
         OP_LW, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            ctrl_o.we = 1'b1;
            ctrl_o.wa = rt_i;
         end
         OP_JAL: begin
            ctrl_o.we = 1'b1;
            ctrl_o.wa = RA_IDX;
         end
         OP_SW, OP_BEQ, OP_BNE, OP_J: ctrl_o = '0;
         default:                     ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/reg_file_wb.sv
// Architectural GPR file with combinational rs/rt/debug reads and a single
// clocked writeback port, plus a counter of committed non-$0 writes.
module reg_file_wb
   import reg_file_wb_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic [31:0]       Ins,
   input  logic [DATA_W-1:0] Wdata,
   output logic [DATA_W-1:0] Rdata1,
   output logic [DATA_W-1:0] Rdata2,
   input  logic [AW-1:0]     DbgAdr,
   output logic [DATA_W-1:0] DbgData,
   output logic [31:0]       WrCount
);

   logic [DATA_W-1:0] gpr_q [NREG];
   logic [31:0]       wr_count_q;
   logic [31:0]       wr_count_d;
   wb_ctrl_t          wb_ctrl;
   logic              commit;
   logic [AW-1:0]     rs_idx;
   logic [AW-1:0]     rt_idx;
   logic              unused_shamt;

   assign rs_idx       = Ins[25:21];
   assign rt_idx       = Ins[20:16];
   assign unused_shamt = ^Ins[10:6];

   reg_file_wb_decode u_wb_decode (
      .opcode_i (Ins[31:26]),
      .rt_i     (rt_idx),
      .rd_i     (Ins[15:11]),
      .funct_i  (Ins[5:0]),
      .ctrl_o   (wb_ctrl)
   );

   // Writes to $0 are discarded entirely and do not count as commits
   assign commit     = wb_ctrl.we && (wb_ctrl.wa != '0);
   assign wr_count_d = wr_count_q + 32'd1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NREG; i++) begin
            gpr_q[i] <= '0;
         end
         wr_count_q <= '0;
      end else if (commit) begin
         gpr_q[wb_ctrl.wa] <= Wdata;
         wr_count_q        <= wr_count_d;
      end
   end

   // Reads see the pre-edge array, so an instruction reads its sources before its own writeback
   assign Rdata1  = (rs_idx == '0) ? '0 : gpr_q[rs_idx];
   assign Rdata2  = (rt_idx == '0) ? '0 : gpr_q[rt_idx];
   assign DbgData = (DbgAdr == '0) ? '0 : gpr_q[DbgAdr];
   assign WrCount = wr_count_q;

endmodule
